// File: rtl/ucisc_debug_pkg.sv
// Shared types and default widths for the cpu clock-path debug logic.
package ucisc_debug_pkg;

  typedef enum logic {HALT = 1'b0, RUN = 1'b1} stepper_state_t;

  localparam int DEFAULT_DEBOUNCE_WIDTH = 16;
  localparam int DEFAULT_DIV_WIDTH      = 18;
  localparam int DEFAULT_ADDR_WIDTH     = 16;

endpackage

// File: rtl/button_debouncer.sv
// Raw push-button to one-cycle press pulse: 2-flop synchroniser, saturating
// disagreement counter, stable register and registered rising-edge pulse.
module button_debouncer
  import ucisc_debug_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = DEFAULT_DEBOUNCE_WIDTH
) (
  input  logic clock_input,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic [1:0]                sync;
  logic                      stable;
  logic [DEBOUNCE_WIDTH-1:0] cnt;

  always_ff @(posedge clock_input) begin
    if (reset) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], button};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (&cnt) begin
        // pulse lands on the same edge the stable value flips, so the
        // downstream FSM sees it one edge later
        stable <= sync[1];
        cnt    <= '0;
        press  <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_stepper.sv
// CPU clock-enable generator: single-step on debounced presses in HALT, divided
// free-running tick in RUN. Breakpoint halt under CLOCK_STEPPER_BREAKPOINT_EN.
module clock_stepper
  import ucisc_debug_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = DEFAULT_DEBOUNCE_WIDTH,
  parameter int DIV_WIDTH      = DEFAULT_DIV_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock_input,
  input  logic                  reset,
  input  logic                  step_button,
  input  logic                  mode_button,
`ifdef CLOCK_STEPPER_BREAKPOINT_EN
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] break_addr,
  input  logic                  break_valid,
  output logic                  break_hit,
`endif
  output logic                  step_tick,
  output logic                  running
);

  localparam int BTN_STEP = 0;
  localparam int BTN_MODE = 1;

  logic [1:0]           raw_btn;
  logic [1:0]           press;
  stepper_state_t       state;
  logic [DIV_WIDTH-1:0] div;
  logic                 bp_match;

  assign raw_btn = {mode_button, step_button};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    button_debouncer #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_db (
      .clock_input (clock_input),
      .reset       (reset),
      .button      (raw_btn[i]),
      .press       (press[i])
    );
  end

`ifdef CLOCK_STEPPER_BREAKPOINT_EN
  assign bp_match = break_valid && (pc == break_addr);

  always_ff @(posedge clock_input) begin
    if (reset)
      break_hit <= 1'b0;
    else if (state == RUN && bp_match)
      break_hit <= 1'b1;
    else if (state == HALT && (|press))
      break_hit <= 1'b0;
  end
`else
  logic [ADDR_WIDTH-1:0] addr_unused;  // ADDR_WIDTH only matters with breakpoints
  assign addr_unused = '0;
  assign bp_match    = 1'b0;
`endif

  always_ff @(posedge clock_input) begin
    if (reset) begin
      state     <= HALT;
      running   <= 1'b0;
      step_tick <= 1'b0;
      div       <= '0;
    end else begin
      step_tick <= 1'b0;
      case (state)
        HALT: begin
          if (press[BTN_MODE]) begin
            state   <= RUN;
            running <= 1'b1;
            div     <= '0;
          end else if (press[BTN_STEP]) begin
            step_tick <= 1'b1;
          end
        end
        RUN: begin
          div <= div + 1'b1;
          // leaving RUN swallows any tick due on the same edge
          if (bp_match || press[BTN_MODE]) begin
            state   <= HALT;
            running <= 1'b0;
          end else if (&div) begin
            step_tick <= 1'b1;
          end
        end
        default: begin
          state   <= HALT;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
